instruction_cache_line: RTL and testbench
=========================================

// Module: instruction_cache_line
// PURPOSE
//  Single-line (32-word) instruction cache between program ROM and decoder, downstream of program_sequencer.
//  Captures ROM words during a sequencer line fill (cache_wren/cache_wroffset), tracks line tag and per-word valid.
//  Returns registered instruction at cache_rdoffset; while sequencer holds or word not yet valid, issues NOP bubble.
// PARAMETERS
//  DATA_W     8      instruction / ROM data width
//  OFFSET_W   5      word offset width; line depth = 2**OFFSET_W = 32
//  TAG_W      3      line tag width (pc[7:5])
//  NOP_INSTR  8'h00  instruction emitted on bubble and after reset
// PORTS
//  clk             in   1         clock, all state on rising edge
//  reset_n         in   1         asynchronous, active-low reset
//  cache_wren      in   1         write ROM word into line this cycle
//  cache_wroffset  in   OFFSET_W  word offset being written
//  rom_data        in   DATA_W    ROM read data aligned with cache_wren
//  fill_tag        in   TAG_W     tag of the line being filled
//  cache_rdoffset  in   OFFSET_W  word offset to fetch (pc[4:0])
//  rd_tag          in   TAG_W     tag of the fetch address (pc[7:5])
//  hold_in         in   1         sequencer hold_out; forces bubble
//  ir              out  DATA_W    registered instruction to decoder
//  ir_valid        out  1         ir holds a real fetched instruction
//  hit             out  1         comb: rd_tag==line_tag && word_valid[cache_rdoffset]
//  line_valid      out  1         all 32 words of current line valid
//  line_tag        out  TAG_W     tag of line held/being filled
//  fill_done       out  1         1-cycle pulse after word 31 written completes the line
// BEHAVIOUR
//  Reset (reset_n=0, immediate): ir=NOP_INSTR, ir_valid=0, line_valid=0, line_tag=0, fill_done=0,
//   word_valid[31:0]=0, wren_d=0; data array not reset (contents don't-care until valid).
//  Storage: 32 x DATA_W registers; cache_wren=1 -> mem[cache_wroffset]<=rom_data, word_valid[offset]<=1.
//  Fill start: cache_wren && cache_wroffset==0 && !wren_d (wren_d = cache_wren delayed 1 clk):
//   line_tag<=fill_tag; word_valid<=32'h1; line_valid<=0. Overrides any partial fill (restart).
//  Fill end: write to offset 31 while word_valid[30:0] all 1 -> line_valid<=1, fill_done pulses next cycle.
//   Write to 31 with gaps -> no line_valid, no fill_done (line stays partially valid).
//  Writes while cache_wren at offset!=0 with no fill start: update word, set its valid, tag unchanged.
//  Fetch (1 clk latency, registered):
//   hold_in=1              -> ir<=NOP_INSTR, ir_valid<=0
//   else hit=0             -> ir<=NOP_INSTR, ir_valid<=0
//   else                   -> ir<=mem[cache_rdoffset], ir_valid<=1
//  Write bypass: cache_wren && cache_wroffset==cache_rdoffset && fill_tag==rd_tag
//   -> counts as hit; ir<=rom_data (not stale mem) unless hold_in=1.
//  hit during fill-start cycle uses new tag/valid (i.e. word 0 bypass only).
//  Offsets are exact OFFSET_W bits; no wrap logic needed (counter owned by sequencer).
//  reset_n asserted mid-fill: fill abandoned, line invalid; next fill must restart at offset 0.
//  fill_done and line_valid never asserted in same cycle as fill start.
// TESTING
//  1 Reset release, no writes, rd_tag=0 off=0 hold_in=0 -> hit=0, ir=8'h00, ir_valid=0 every cycle.
//  2 Fill tag=3, offsets 0..31 data=8'hA0+off -> line_valid=1 and fill_done=1 for exactly 1 clk after
//    off 31; then rd_tag=3 off=5 -> ir=8'hA5, ir_valid=1 one clk later.
//  3 During fill of tag=2, rd_tag=2 off=7 held while write off=7 data=8'h3C hold_in=0 -> ir=8'h3C next clk
//    (bypass); off=9 before written -> ir=NOP, ir_valid=0.
//  4 Complete line tag=1, then start fill tag=4, abort after off 10, restart off 0..31 -> one fill_done,
//    line_tag=4; rd_tag=1 -> hit=0.
//  5 Valid line, hit=1, hold_in=1 for 3 clks -> ir=NOP, ir_valid=0 for 3 clks, valid instr resumes next clk.
//  6 reset_n low at off 20 mid-fill (async, between edges) -> outputs zero immediately, line_valid=0.

Source files
------------

// File: rtl/instruction_cache_line_if.sv
// Bus between the program sequencer / ROM side and the single-line instruction cache.
//   master : sequencer side, drives fill writes and fetch requests, observes fetch results.
//   slave  : the cache itself.
// Signals:
//   cache_wren, cache_wroffset, rom_data, fill_tag : line-fill write port
//   cache_rdoffset, rd_tag, hold_in                : fetch request
//   ir, ir_valid                                   : registered fetch result
//   hit, line_valid, line_tag, fill_done           : line status
interface instruction_cache_line_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OFFSET_W = 5,
  parameter int unsigned TAG_W    = 3
);
  logic                cache_wren;
  logic [OFFSET_W-1:0] cache_wroffset;
  logic [DATA_W-1:0]   rom_data;
  logic [TAG_W-1:0]    fill_tag;
  logic [OFFSET_W-1:0] cache_rdoffset;
  logic [TAG_W-1:0]    rd_tag;
  logic                hold_in;
  logic [DATA_W-1:0]   ir;
  logic                ir_valid;
  logic                hit;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic                fill_done;

  modport master (
    output cache_wren,
    output cache_wroffset,
    output rom_data,
    output fill_tag,
    output cache_rdoffset,
    output rd_tag,
    output hold_in,
    input  ir,
    input  ir_valid,
    input  hit,
    input  line_valid,
    input  line_tag,
    input  fill_done
  );

  modport slave (
    input  cache_wren,
    input  cache_wroffset,
    input  rom_data,
    input  fill_tag,
    input  cache_rdoffset,
    input  rd_tag,
    input  hold_in,
    output ir,
    output ir_valid,
    output hit,
    output line_valid,
    output line_tag,
    output fill_done
  );
endinterface

// File: rtl/instruction_cache_line.sv
// Single-line instruction cache sitting between program ROM and the decoder.
// The sequencer streams a line of ROM words in (cache_wren / cache_wroffset); the cache records
// the line tag and a valid bit per word, and returns a registered instruction for the fetch
// offset one clock later. Held fetches and misses produce a NOP bubble.
// Ports:
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of instruction_cache_line_if (fill port, fetch port, status)
module instruction_cache_line #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       OFFSET_W  = 5,
  parameter int unsigned       TAG_W     = 3,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input logic                     clk,
  input logic                     reset_n,
  instruction_cache_line_if.slave bus
);

  localparam int unsigned DEPTH = 1 << OFFSET_W;

  // Storage and state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  word_valid_q, word_valid_d;
  logic [TAG_W-1:0]  line_tag_q, line_tag_d;
  logic              line_valid_q, line_valid_d;
  logic              fill_done_q, fill_done_d;
  logic              wren_dly_q;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;

  // Decoded events
  logic fill_start;
  logic fill_complete;
  logic bypass;
  logic stored_hit;
  logic hit;

  // A fill begins on the rising edge of a write burst at offset 0; a write at offset 0 in the
  // middle of a burst is just an ordinary word update.
  assign fill_start = bus.cache_wren && (bus.cache_wroffset == '0) && !wren_dly_q;

  // The line completes when the last word lands on top of an otherwise fully valid line.
  assign fill_complete = bus.cache_wren && !fill_start &&
                         (bus.cache_wroffset == {OFFSET_W{1'b1}}) &&
                         (&word_valid_q[DEPTH-2:0]);

  // The word being written this cycle can be forwarded straight to the fetch path.
  assign bypass = bus.cache_wren &&
                  (bus.cache_wroffset == bus.cache_rdoffset) &&
                  (bus.fill_tag == bus.rd_tag);

  // On a fill-start cycle the old line is being discarded, so only the bypassed word 0 of the
  // new line can hit.
  assign stored_hit = !fill_start &&
                      (bus.rd_tag == line_tag_q) &&
                      word_valid_q[bus.cache_rdoffset];

  assign hit = stored_hit || bypass;

  // Line bookkeeping next state
  always_comb begin
    word_valid_d = word_valid_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    fill_done_d  = 1'b0;

    if (fill_start) begin
      line_tag_d   = bus.fill_tag;
      word_valid_d = {{(DEPTH-1){1'b0}}, 1'b1};
      line_valid_d = 1'b0;
    end else if (bus.cache_wren) begin
      word_valid_d[bus.cache_wroffset] = 1'b1;
      if (fill_complete) begin
        line_valid_d = 1'b1;
        fill_done_d  = 1'b1;
      end
    end
  end

  // Fetch path next state
  always_comb begin
    ir_d       = NOP_INSTR;
    ir_valid_d = 1'b0;

    if (!bus.hold_in && hit) begin
      ir_valid_d = 1'b1;
      ir_d       = bypass ? bus.rom_data : mem_q[bus.cache_rdoffset];
    end
  end

  // Data array carries no reset; contents only matter once their valid bit is set.
  always_ff @(posedge clk) begin
    if (bus.cache_wren) begin
      mem_q[bus.cache_wroffset] <= bus.rom_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_valid_q <= '0;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      fill_done_q  <= 1'b0;
      wren_dly_q   <= 1'b0;
      ir_q         <= NOP_INSTR;
      ir_valid_q   <= 1'b0;
    end else begin
      word_valid_q <= word_valid_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      fill_done_q  <= fill_done_d;
      wren_dly_q   <= bus.cache_wren;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
    end
  end

  assign bus.ir         = ir_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.hit        = hit;
  assign bus.line_valid = line_valid_q;
  assign bus.line_tag   = line_tag_q;
  assign bus.fill_done  = fill_done_q;

endmodule

// File: tb/tb_instruction_cache_line.sv
// Bench for instruction_cache_line: directed scenarios followed by a randomized fill/fetch phase,
// all checked against a word-array model of the cache.
module tb_instruction_cache_line;

  logic clk;
  logic reset_n;

  instruction_cache_line_if #(.DATA_W(8), .OFFSET_W(5), .TAG_W(3)) bus ();

  instruction_cache_line #(
    .DATA_W   (8),
    .OFFSET_W (5),
    .TAG_W    (3),
    .NOP_INSTR(8'h00)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the line holds, in plain array form
  logic [7:0] m_mem   [32];
  bit         m_valid [32];
  logic [2:0] m_tag;
  bit         m_lv;
  bit         m_fd;
  bit         m_irv;
  bit         m_prev_wren;
  logic [7:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 0;
    m_tag       = 3'd0;
    m_lv        = 0;
    m_fd        = 0;
    m_irv       = 0;
    m_prev_wren = 0;
    m_ir        = 8'h00;
  endtask

  // One clock: drive inputs, check the combinational hit, clock, then check registered outputs.
  task automatic cyc(input bit wren, input logic [4:0] woff, input logic [7:0] data,
                     input logic [2:0] ftag, input logic [4:0] roff, input logic [2:0] rtag,
                     input bit hold);
    bit         start, byp, hit_e, lower_full, complete;
    logic [7:0] ir_e;
    bus.cache_wren     = wren;
    bus.cache_wroffset = woff;
    bus.rom_data       = data;
    bus.fill_tag       = ftag;
    bus.cache_rdoffset = roff;
    bus.rd_tag         = rtag;
    bus.hold_in        = hold;
    #1;
    start = wren && (woff == 5'd0) && !m_prev_wren;
    byp   = wren && (woff == roff) && (ftag == rtag);
    if (start) hit_e = byp;
    else       hit_e = byp || ((rtag == m_tag) && m_valid[roff]);
    chk("hit", {31'b0, bus.hit}, {31'b0, hit_e});

    lower_full = 1;
    for (int i = 0; i < 31; i++) if (!m_valid[i]) lower_full = 0;
    complete = wren && (woff == 5'd31) && lower_full && !start;

    if (hold || !hit_e) ir_e = 8'h00;
    else if (byp)       ir_e = data;
    else                ir_e = m_mem[roff];

    @(posedge clk);
    #1;
    if (start) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 0;
      m_tag = ftag;
      m_lv  = 0;
    end
    if (wren) begin
      m_mem[woff]   = data;
      m_valid[woff] = 1;
    end
    if (complete) m_lv = 1;
    m_fd        = complete;
    m_ir        = ir_e;
    m_irv       = !hold && hit_e;
    m_prev_wren = wren;

    chk("ir", {24'b0, bus.ir}, {24'b0, m_ir});
    chk("ir_valid", {31'b0, bus.ir_valid}, {31'b0, m_irv});
    chk("line_valid", {31'b0, bus.line_valid}, {31'b0, m_lv});
    chk("line_tag", {29'b0, bus.line_tag}, {29'b0, m_tag});
    chk("fill_done", {31'b0, bus.fill_done}, {31'b0, m_fd});
  endtask

  task automatic idle(input logic [4:0] roff, input logic [2:0] rtag, input bit hold);
    cyc(0, 5'd0, 8'h00, 3'd0, roff, rtag, hold);
  endtask

  int         fd_cnt;
  logic [4:0] ptr;
  logic [2:0] cur_tag;
  bit         w;

  initial begin
    reset_n = 1'b0;
    bus.cache_wren     = 0;
    bus.cache_wroffset = '0;
    bus.rom_data       = '0;
    bus.fill_tag       = '0;
    bus.cache_rdoffset = '0;
    bus.rd_tag         = '0;
    bus.hold_in        = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", {24'b0, bus.ir}, 32'h0);
    chk("rst_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
    chk("rst_line_valid", {31'b0, bus.line_valid}, 32'h0);
    chk("rst_fill_done", {31'b0, bus.fill_done}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: idle after reset, fetch tag 0 offset 0 never hits
    repeat (4) idle(5'd0, 3'd0, 0);

    // 2: full fill of tag 3, then fetch offset 5
    fd_cnt = 0;
    for (int o = 0; o < 32; o++) begin
      cyc(1, o[4:0], 8'hA0 + o[7:0], 3'd3, 5'd0, 3'd0, 0);
      if (bus.fill_done) fd_cnt++;
    end
    chk("t2_line_valid", {31'b0, bus.line_valid}, 32'h1);
    idle(5'd5, 3'd3, 0);
    if (bus.fill_done) fd_cnt++;
    chk("t2_fill_done_count", fd_cnt, 1);
    chk("t2_ir", {24'b0, bus.ir}, 32'hA5);
    chk("t2_ir_valid", {31'b0, bus.ir_valid}, 32'h1);

    // 3: bypass of word 7 during a tag 2 fill, then a not-yet-written word misses
    for (int o = 0; o < 7; o++) cyc(1, o[4:0], 8'($urandom), 3'd2, 5'd7, 3'd2, 0);
    cyc(1, 5'd7, 8'h3C, 3'd2, 5'd7, 3'd2, 0);
    chk("t3_bypass_ir", {24'b0, bus.ir}, 32'h3C);
    cyc(1, 5'd8, 8'($urandom), 3'd2, 5'd9, 3'd2, 0);
    chk("t3_miss_ir", {24'b0, bus.ir}, 32'h0);
    chk("t3_miss_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
    idle(5'd9, 3'd2, 0);

    // 4: complete tag 1, abort tag 4 after offset 10, restart tag 4 in full
    for (int o = 0; o < 32; o++) cyc(1, o[4:0], 8'($urandom), 3'd1, 5'd3, 3'd1, 0);
    idle(5'd3, 3'd1, 0);
    fd_cnt = 0;
    for (int o = 0; o <= 10; o++) begin
      cyc(1, o[4:0], 8'($urandom), 3'd4, 5'd3, 3'd1, 0);
      if (bus.fill_done) fd_cnt++;
    end
    repeat (2) idle(5'd3, 3'd1, 0);
    for (int o = 0; o < 32; o++) begin
      cyc(1, o[4:0], 8'($urandom), 3'd4, 5'($urandom), 3'($urandom_range(0, 4)), 0);
      if (bus.fill_done) fd_cnt++;
    end
    idle(5'd3, 3'd1, 0);
    if (bus.fill_done) fd_cnt++;
    chk("t4_fill_done_count", fd_cnt, 1);
    chk("t4_line_tag", {29'b0, bus.line_tag}, 32'h4);
    chk("t4_old_tag_ir_valid", {31'b0, bus.ir_valid}, 32'h0);

    // 5: hold for three clocks on a hitting fetch
    idle(5'd2, 3'd4, 0);
    chk("t5_pre_hold", {31'b0, bus.ir_valid}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      idle(5'd2, 3'd4, 1);
      chk("t5_hold_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
    end
    idle(5'd2, 3'd4, 0);
    chk("t5_resume", {31'b0, bus.ir_valid}, 32'h1);

    // 6: asynchronous reset in the middle of a tag 5 fill
    for (int o = 0; o <= 20; o++) cyc(1, o[4:0], 8'($urandom), 3'd5, 5'd0, 3'd5, 0);
    bus.cache_wren = 0;
    bus.rd_tag     = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_ir", {24'b0, bus.ir}, 32'h0);
    chk("t6_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
    chk("t6_line_valid", {31'b0, bus.line_valid}, 32'h0);
    chk("t6_line_tag", {29'b0, bus.line_tag}, 32'h0);
    chk("t6_fill_done", {31'b0, bus.fill_done}, 32'h0);
    chk("t6_hit", {31'b0, bus.hit}, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(5'd0, 3'd5, 0);

    // Randomized fills with gaps, restarts, holds and mixed fetch tags
    ptr     = 5'd0;
    cur_tag = 3'($urandom);
    for (int n = 0; n < 800; n++) begin
      w = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        ptr     = 5'd0;
        w       = 0;
        cur_tag = 3'($urandom);
      end
      cyc(w, ptr, 8'($urandom), cur_tag, 5'($urandom),
          ($urandom_range(0, 3) != 0) ? cur_tag : 3'($urandom), ($urandom_range(0, 4) == 0));
      if (w) begin
        if (ptr == 5'd31) cur_tag = 3'($urandom);
        ptr = ptr + 5'd1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
